hms_time_counter: RTL

- Upstream stage of the 6-digit seven-segment display path.
- Generates a 1 Hz time base from clk and keeps an HH:MM:SS time-of-day count in six BCD digits.
- Digits feed the per-digit seven-segment decoders, which feed the display scanner.
- Provides run/stop, clear and stopped-mode field adjustment driven by single-cycle key pulses from the debounce stage.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/bcd_pair_counter.sv | 59 +++++
 rtl/hms_time_counter.sv | 114 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path.
// Field selects, BCD limits and the run/stop state type.
package seg_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [1:0] SEL_SEC  = 2'd0;
   localparam logic [1:0] SEL_MIN  = 2'd1;
   localparam logic [1:0] SEL_HOUR = 2'd2;
   localparam logic [1:0] SEL_NONE = 2'd3;

   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;
   localparam int HOUR_MAX = 23;

   typedef enum logic {
      ST_STOPPED = 1'b0,
      ST_RUNNING = 1'b1
   } run_state_e;

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter wrapping MAX -> 00.
// carry flags an inc that causes the wrap.
module bcd_pair_counter
   import seg_pkg::*;
#(
   parameter int MAX = 59
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               inc,
   input  logic               clr,
   output logic [DIGIT_W-1:0] tens,
   output logic [DIGIT_W-1:0] ones,
   output logic               carry
);

   localparam logic [DIGIT_W-1:0] MAX_T = DIGIT_W'(MAX / 10);
   localparam logic [DIGIT_W-1:0] MAX_O = DIGIT_W'(MAX % 10);

   logic [DIGIT_W-1:0] tens_q, tens_d;
   logic [DIGIT_W-1:0] ones_q, ones_d;
   logic               at_max;

   assign at_max = (tens_q == MAX_T) && (ones_q == MAX_O);
   assign carry  = inc && !clr && at_max;

   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      if (clr) begin
         tens_d = '0;
         ones_d = '0;
      end else if (inc) begin
         if (at_max) begin
            tens_d = '0;
            ones_d = '0;
         end else if (ones_q == DIGIT_W'(9)) begin
            tens_d = tens_q + DIGIT_W'(1);
            ones_d = '0;
         end else begin
            ones_d = ones_q + DIGIT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tens_q <= '0;
         ones_q <= '0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign tens = tens_q;
   assign ones = ones_q;

endmodule

// File: rtl/hms_time_counter.sv
// HH:MM:SS time-of-day counter with 1 Hz prescaler,
// run/stop, clear and stopped-mode field adjust.
module hms_time_counter
   import seg_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int CNT_W    = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run_tgl,
   input  logic               clr,
   input  logic               adj_inc,
   input  logic [1:0]         adj_sel,
   output logic               running,
   output logic               tick_1hz,
   output logic [DIGIT_W-1:0] hour_t,
   output logic [DIGIT_W-1:0] hour_o,
   output logic [DIGIT_W-1:0] min_t,
   output logic [DIGIT_W-1:0] min_o,
   output logic [DIGIT_W-1:0] sec_t,
   output logic [DIGIT_W-1:0] sec_o
);

   localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

   run_state_e       state_q, state_d;
   logic [CNT_W-1:0] presc_q, presc_d;
   logic             tick_q, tick_d;

   logic adj_ok;
   logic sec_inc, min_inc, hour_inc;
   logic sec_carry, min_carry, hour_carry_unused;

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      tick_d  = 1'b0;
      if (run_tgl) begin
         state_d = (state_q == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
      end
      // A toggle swallows any wrap pending in the same cycle.
      if (clr) begin
         presc_d = '0;
      end else if (run_tgl) begin
         if (state_q == ST_STOPPED) presc_d = '0;
      end else if (state_q == ST_RUNNING) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
         end else begin
            presc_d = presc_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_STOPPED;
         presc_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
      end
   end

   assign adj_ok = adj_inc && !clr && !run_tgl
                && (state_q == ST_STOPPED)
                && (adj_sel != SEL_NONE);

   // Adjust never ripples; only ticks propagate carries.
   assign sec_inc  = tick_d
                  || (adj_ok && adj_sel == SEL_SEC);
   assign min_inc  = (tick_d && sec_carry)
                  || (adj_ok && adj_sel == SEL_MIN);
   assign hour_inc = (tick_d && min_carry)
                  || (adj_ok && adj_sel == SEL_HOUR);

   bcd_pair_counter #(.MAX(SEC_MAX)) u_sec (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (sec_inc),
      .clr   (clr),
      .tens  (sec_t),
      .ones  (sec_o),
      .carry (sec_carry)
   );

   bcd_pair_counter #(.MAX(MIN_MAX)) u_min (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (min_inc),
      .clr   (clr),
      .tens  (min_t),
      .ones  (min_o),
      .carry (min_carry)
   );

   bcd_pair_counter #(.MAX(HOUR_MAX)) u_hour (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hour_inc),
      .clr   (clr),
      .tens  (hour_t),
      .ones  (hour_o),
      .carry (hour_carry_unused)
   );

   assign running  = (state_q == ST_RUNNING);
   assign tick_1hz = tick_q;

endmodule
